// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's load/store port.
// Byte-laned stores commit on the rising edge; loads are combinational with
// alignment and sign/zero extension. Illegal stores are dropped and recorded
// in a sticky first-error capture block with a saturating error counter.
module data_mem_responder #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Mem_WrAddr,
    input  logic [31:0] Mem_WrData,
    input  logic [2:0]  Mem_Funct3,
    output logic [31:0] ReadData,
    output logic        err_valid,
    output logic [31:0] err_addr,
    output logic [1:0]  err_cause,
    output logic [7:0]  err_count,
    input  logic        err_clr
);

    localparam logic [31:0] ByteLimit = 32'(DEPTH * 4);

    localparam logic [2:0] F3B  = 3'b000;
    localparam logic [2:0] F3H  = 3'b001;
    localparam logic [2:0] F3W  = 3'b010;
    localparam logic [2:0] F3BU = 3'b100;
    localparam logic [2:0] F3HU = 3'b101;

    localparam logic [1:0] CauseNone     = 2'b00;
    localparam logic [1:0] CauseMisalign = 2'b01;
    localparam logic [1:0] CauseRange    = 2'b10;
    localparam logic [1:0] CauseFunct3   = 2'b11;

    logic [31:0]   mem_q [DEPTH];

    logic [AW-1:0] word_idx;
    logic [1:0]    off;
    logic          in_range;

    logic [31:0]   rd_word;
    logic [15:0]   rd_half;
    logic [7:0]    rd_byte;

    logic [1:0]    st_cause;
    logic          st_err;
    logic          st_ok;
    logic          mem_we;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;

    logic          err_valid_q, err_valid_d;
    logic [31:0]   err_addr_q,  err_addr_d;
    logic [1:0]    err_cause_q, err_cause_d;
    logic [7:0]    err_count_q, err_count_d;

    assign word_idx = Mem_WrAddr[AW+1:2];
    assign off      = Mem_WrAddr[1:0];
    assign in_range = (Mem_WrAddr < ByteLimit);

    // Load path: select the word, then the half/byte lane, then extend.
    always_comb begin
        rd_word  = in_range ? mem_q[word_idx] : 32'h0;
        rd_half  = off[1] ? rd_word[31:16] : rd_word[15:0];
        rd_byte  = rd_word[8*off +: 8];
        ReadData = 32'h0;
        case (Mem_Funct3)
            F3B:     ReadData = {{24{rd_byte[7]}}, rd_byte};
            F3BU:    ReadData = {24'h0, rd_byte};
            F3H:     ReadData = {{16{rd_half[15]}}, rd_half};
            F3HU:    ReadData = {16'h0, rd_half};
            F3W:     ReadData = rd_word;
            default: ReadData = 32'h0;
        endcase
    end

    // Store legality with priority funct3 > range > alignment, plus lane enables.
    always_comb begin
        st_cause  = CauseNone;
        lane_en   = 4'b0000;
        lane_data = Mem_WrData;
        if (!(Mem_Funct3 inside {F3B, F3H, F3W})) begin
            st_cause = CauseFunct3;
        end else if (!in_range) begin
            st_cause = CauseRange;
        end else if ((Mem_Funct3 == F3H && off[0]) || (Mem_Funct3 == F3W && off != 2'b00)) begin
            st_cause = CauseMisalign;
        end
        case (Mem_Funct3)
            F3B: begin
                lane_en   = 4'b0001 << off;
                lane_data = {4{Mem_WrData[7:0]}};
            end
            F3H: begin
                lane_en   = off[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{Mem_WrData[15:0]}};
            end
            F3W: begin
                lane_en   = 4'b1111;
                lane_data = Mem_WrData;
            end
            default: begin
                lane_en   = 4'b0000;
                lane_data = Mem_WrData;
            end
        endcase
    end

    assign st_err = MemWrite && (st_cause != CauseNone);
    assign st_ok  = MemWrite && (st_cause == CauseNone);
    // Reset low at the edge discards the store entirely.
    assign mem_we = st_ok && reset;

    // Byte-laned memory write; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem_q[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    // Error block next state: a new error beats a same-cycle clear.
    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_cause_d = err_cause_q;
        err_count_d = err_count_q;
        if (st_err) begin
            err_valid_d = 1'b1;
            if (!err_valid_q || err_clr) begin
                err_addr_d  = Mem_WrAddr;
                err_cause_d = st_cause;
            end
            if (err_clr) begin
                err_count_d = 8'd1;
            end else if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end else if (err_clr) begin
            err_valid_d = 1'b0;
            err_addr_d  = 32'h0;
            err_cause_d = CauseNone;
            err_count_d = 8'd0;
        end
    end

    // Error block state with asynchronous clear on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= 32'h0;
            err_cause_q <= CauseNone;
            err_count_q <= 8'd0;
        end else begin
            err_valid_q <= err_valid_d;
            err_addr_q  <= err_addr_d;
            err_cause_q <= err_cause_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_addr  = err_addr_q;
    assign err_cause = err_cause_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed scenarios followed by
// randomized loads/stores checked against a byte-addressed reference model.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic [2:0]  Mem_Funct3;
    logic [31:0] ReadData;
    logic        err_valid;
    logic [31:0] err_addr;
    logic [1:0]  err_cause;
    logic [7:0]  err_count;
    logic        err_clr;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    logic [7:0]  ref_mem [int];
    bit          m_valid;
    logic [31:0] m_addr;
    logic [1:0]  m_cause;
    int          m_cnt;

    data_mem_responder #(.DEPTH(1024), .AW(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWrite   (MemWrite),
        .Mem_WrAddr (Mem_WrAddr),
        .Mem_WrData (Mem_WrData),
        .Mem_Funct3 (Mem_Funct3),
        .ReadData   (ReadData),
        .err_valid  (err_valid),
        .err_addr   (err_addr),
        .err_cause  (err_cause),
        .err_count  (err_count),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 8'hxx;
    endfunction

    // Expected load value; X where the addressed bytes were never written.
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] f);
        logic [31:0] base;
        logic [7:0]  b0, b1;
        if (a >= 32'd4096 || f inside {3'd3, 3'd6, 3'd7}) return 32'h0;
        case (f)
            3'd0, 3'd4: begin
                b0 = get_byte(a);
                return (f == 3'd0) ? {{24{b0[7]}}, b0} : {24'h0, b0};
            end
            3'd1, 3'd5: begin
                base = (a & ~32'd3) + ((a & 32'd2));
                b0 = get_byte(base);
                b1 = get_byte(base + 1);
                return (f == 3'd1) ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
            end
            default: begin
                base = a & ~32'd3;
                return {get_byte(base + 3), get_byte(base + 2), get_byte(base + 1), get_byte(base)};
            end
        endcase
    endfunction

    function automatic logic [1:0] model_cause(input logic [31:0] a, input logic [2:0] f);
        if (f > 3'd2) return 2'b11;
        if (a >= 32'd4096) return 2'b10;
        if ((f == 3'd1 && a[0]) || (f == 3'd2 && a[1:0] != 2'b00)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_update(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] f, input logic clr);
        logic [1:0]  c;
        logic [31:0] base;
        c = model_cause(a, f);
        if (we && c != 2'b00) begin
            if (!m_valid || clr) begin
                m_addr  = a;
                m_cause = c;
            end
            m_cnt   = clr ? 1 : ((m_cnt + 1 > 255) ? 255 : m_cnt + 1);
            m_valid = 1'b1;
        end else begin
            if (clr) begin
                m_valid = 1'b0;
                m_addr  = 32'h0;
                m_cause = 2'b00;
                m_cnt   = 0;
            end
            if (we) begin
                if (f == 3'd0) begin
                    ref_mem[int'(a)] = d[7:0];
                end else if (f == 3'd1) begin
                    ref_mem[int'(a)]     = d[7:0];
                    ref_mem[int'(a) + 1] = d[15:8];
                end else begin
                    base = a & ~32'd3;
                    for (int i = 0; i < 4; i++) ref_mem[int'(base) + i] = d[8*i +: 8];
                end
            end
        end
    endtask

    task automatic check_err(input string tag);
        check({tag, ".valid"}, {31'h0, err_valid}, {31'h0, m_valid});
        check({tag, ".addr"},  err_addr, m_addr);
        check({tag, ".cause"}, {30'h0, err_cause}, {30'h0, m_cause});
        check({tag, ".count"}, {24'h0, err_count}, 32'(m_cnt));
    endtask

    // One clocked access; ReadData is checked against pre-edge contents.
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, input logic clr, input string tag);
        logic [31:0] exp;
        MemWrite   = we;
        Mem_WrAddr = a;
        Mem_WrData = d;
        Mem_Funct3 = f;
        err_clr    = clr;
        #1;
        exp = model_load(a, f);
        if (!$isunknown(exp)) check({tag, ".rd_old"}, ReadData, exp);
        @(posedge clk);
        model_update(we, a, d, f, clr);
        #1;
        MemWrite = 1'b0;
        err_clr  = 1'b0;
        check_err(tag);
    endtask

    task automatic load(input logic [31:0] a, input logic [2:0] f, input logic [31:0] exp,
                        input string tag);
        MemWrite   = 1'b0;
        err_clr    = 1'b0;
        Mem_WrAddr = a;
        Mem_Funct3 = f;
        @(negedge clk);
        check(tag, ReadData, exp);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [2:0]  f;
        int          op;

        reset      = 1'b0;
        MemWrite   = 1'b0;
        Mem_WrAddr = 32'h0;
        Mem_WrData = 32'h0;
        Mem_Funct3 = 3'b010;
        err_clr    = 1'b0;
        m_valid    = 1'b0;
        m_addr     = 32'h0;
        m_cause    = 2'b00;
        m_cnt      = 0;
        #1;
        check_err("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Load formatting
        cycle(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 1'b0, "sw10");
        load(32'h10, 3'b010, 32'hDEADBEEF, "lw10");
        load(32'h13, 3'b000, 32'hFFFFFFDE, "lb13");
        load(32'h13, 3'b100, 32'h000000DE, "lbu13");
        load(32'h12, 3'b001, 32'hFFFFDEAD, "lh12");
        load(32'h10, 3'b101, 32'h0000BEEF, "lhu10");
        load(32'h10, 3'b011, 32'h0, "lf3_011");

        // Lane isolation
        cycle(1'b1, 32'h20, 32'h11223344, 3'b010, 1'b0, "sw20");
        cycle(1'b1, 32'h21, 32'hFFFFFFAA, 3'b000, 1'b0, "sb21");
        cycle(1'b1, 32'h22, 32'hFFFF5566, 3'b001, 1'b0, "sh22");
        load(32'h20, 3'b010, 32'h5566AA44, "lw20");

        // Misaligned stores: first error captured, later ones only counted
        cycle(1'b1, 32'h30, 32'hCAFEF00D, 3'b010, 1'b0, "sw30");
        cycle(1'b1, 32'h31, 32'h01020304, 3'b010, 1'b0, "sw31");
        load(32'h30, 3'b010, 32'hCAFEF00D, "lw30_kept");
        check("mis.valid", {31'h0, err_valid}, 32'h1);
        check("mis.addr", err_addr, 32'h31);
        check("mis.cause", {30'h0, err_cause}, 32'h1);
        check("mis.count", {24'h0, err_count}, 32'h1);
        cycle(1'b1, 32'h41, 32'h0000BBBB, 3'b001, 1'b0, "sh41");
        check("mis2.addr", err_addr, 32'h31);
        check("mis2.count", {24'h0, err_count}, 32'h2);

        // Out of range, then funct3 priority over range
        cycle(1'b0, 32'h0, 32'h0, 3'b010, 1'b1, "clr1");
        cycle(1'b1, 32'h1000, 32'h77777777, 3'b010, 1'b0, "sw1000");
        check("oor.cause", {30'h0, err_cause}, 32'h2);
        load(32'h1000, 3'b010, 32'h0, "lw1000");
        cycle(1'b0, 32'h0, 32'h0, 3'b010, 1'b1, "clr2");
        cycle(1'b1, 32'h1001, 32'h0, 3'b011, 1'b0, "s011_1001");
        check("prio.cause", {30'h0, err_cause}, 32'h3);

        // Clear and new error in the same cycle, then saturation
        cycle(1'b1, 32'h8, 32'h0, 3'b111, 1'b1, "clr_err");
        check("clrerr.addr", err_addr, 32'h8);
        check("clrerr.count", {24'h0, err_count}, 32'h1);
        for (int i = 0; i < 300; i++) cycle(1'b1, 32'h8, 32'h0, 3'b111, 1'b0, "sat");
        check("sat.count", {24'h0, err_count}, 32'd255);

        // Reset asserted between edges with a store pending
        cycle(1'b1, 32'h50, 32'hA5A55A5A, 3'b010, 1'b0, "sw50");
        MemWrite   = 1'b1;
        Mem_WrAddr = 32'h50;
        Mem_WrData = 32'h12345678;
        Mem_Funct3 = 3'b010;
        #2;
        reset   = 1'b0;
        m_valid = 1'b0;
        m_addr  = 32'h0;
        m_cause = 2'b00;
        m_cnt   = 0;
        #1;
        check_err("async_rst");
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        #1;
        reset = 1'b1;
        load(32'h50, 3'b010, 32'hA5A55A5A, "lw50_kept");
        check_err("post_rst");

        // Randomized phase: fill a region, then mix loads, stores and clears
        for (int i = 0; i < 64; i++) begin
            cycle(1'b1, 32'h100 + 32'(4 * i), $urandom, 3'b010, 1'b0, "fill");
        end
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 9) == 0) ? 32'h1000 + $urandom_range(0, 32'h0FFF_0000)
                                               : 32'h100 + $urandom_range(0, 255);
            d  = $urandom;
            f  = 3'($urandom_range(0, 7));
            if (op < 5) begin
                load(a, f, model_load(a, f), "rnd_ld");
            end else if (op < 9) begin
                cycle(1'b1, a, d, f, ($urandom_range(0, 9) == 0), "rnd_st");
            end else begin
                cycle(1'b0, a, d, f, 1'b1, "rnd_clr");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
